// File: rtl/rop_types.sv
// Shared ROP types: packed color and the per-lane fragment record carried through the queue.
`ifndef ROP_DIM_BITS
`define ROP_DIM_BITS 16
`endif
`ifndef ROP_DEPTH_BITS
`define ROP_DEPTH_BITS 24
`endif

package rop_types;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } rgba_t;

  typedef struct packed {
    logic [`ROP_DIM_BITS-1:0]   pos_x;
    logic [`ROP_DIM_BITS-1:0]   pos_y;
    rgba_t                      color;
    logic [`ROP_DEPTH_BITS-1:0] depth;
    logic                       backface;
  } rop_frag_lane_t;

endpackage

// File: rtl/rop_hazard_check.sv
// Flags an incoming request whose active pixels collide with any active pixel of a live entry.
module rop_hazard_check #(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter int unsigned DIM_BITS    = 16
) (
  input  logic [QUEUE_DEPTH-1:0]                    live_i,
  input  logic [QUEUE_DEPTH*NUM_LANES-1:0]          ent_tmask_i,
  input  logic [QUEUE_DEPTH*NUM_LANES*DIM_BITS-1:0] ent_pos_x_i,
  input  logic [QUEUE_DEPTH*NUM_LANES*DIM_BITS-1:0] ent_pos_y_i,
  input  logic [NUM_LANES-1:0]                      in_tmask_i,
  input  logic [NUM_LANES*DIM_BITS-1:0]             in_pos_x_i,
  input  logic [NUM_LANES*DIM_BITS-1:0]             in_pos_y_i,
  output logic                                      hazard_o
);

  always_comb begin
    hazard_o = 1'b0;
    for (int e = 0; e < QUEUE_DEPTH; e++) begin
      for (int j = 0; j < NUM_LANES; j++) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (live_i[e] && ent_tmask_i[e*NUM_LANES+j] && in_tmask_i[i] &&
              (ent_pos_x_i[(e*NUM_LANES+j)*DIM_BITS +: DIM_BITS] ==
               in_pos_x_i[i*DIM_BITS +: DIM_BITS]) &&
              (ent_pos_y_i[(e*NUM_LANES+j)*DIM_BITS +: DIM_BITS] ==
               in_pos_y_i[i*DIM_BITS +: DIM_BITS])) begin
            hazard_o = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/rop_frag_queue.sv
// In-order fragment request queue; entries stay live from enqueue until the memory pipeline
// retires them, and optionally block overlapping pixel writes while live.
module rop_frag_queue
  import rop_types::*;
#(
  parameter int unsigned NUM_LANES    = 4,
  parameter int unsigned QUEUE_DEPTH  = 8,
  parameter int unsigned DIM_BITS     = `ROP_DIM_BITS,
  parameter int unsigned DEPTH_BITS   = `ROP_DEPTH_BITS,
  parameter int unsigned CHECK_HAZARD = 1,
  localparam int unsigned PtrW        = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enq_valid,
  input  logic [NUM_LANES-1:0]             enq_tmask,
  input  logic [NUM_LANES*DIM_BITS-1:0]    enq_pos_x,
  input  logic [NUM_LANES*DIM_BITS-1:0]    enq_pos_y,
  input  logic [NUM_LANES*32-1:0]          enq_color,
  input  logic [NUM_LANES*DEPTH_BITS-1:0]  enq_depth,
  input  logic [NUM_LANES-1:0]             enq_backface,
  output logic                             enq_ready,
  output logic                             deq_valid,
  output logic [NUM_LANES-1:0]             deq_tmask,
  output logic [NUM_LANES*DIM_BITS-1:0]    deq_pos_x,
  output logic [NUM_LANES*DIM_BITS-1:0]    deq_pos_y,
  output logic [NUM_LANES*32-1:0]          deq_color,
  output logic [NUM_LANES*DEPTH_BITS-1:0]  deq_depth,
  output logic [NUM_LANES-1:0]             deq_backface,
  input  logic                             deq_ready,
  input  logic                             retire_valid,
  output logic [PtrW-1:0]                  pending,
  output logic [31:0]                      stall_count
);

  localparam int unsigned IdxW = PtrW - 1;
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  typedef rop_frag_lane_t [NUM_LANES-1:0] lanes_t;

  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rt_ptr_q, rt_ptr_d;
  logic [31:0]          stall_count_q, stall_count_d;
  logic [NUM_LANES-1:0] tmask_q [QUEUE_DEPTH];
  lanes_t               lane_q  [QUEUE_DEPTH];

  lanes_t                                enq_lanes;
  logic [QUEUE_DEPTH-1:0]                live;
  logic [QUEUE_DEPTH*NUM_LANES-1:0]      ent_tmask;
  logic [QUEUE_DEPTH*NUM_LANES*DIM_BITS-1:0] ent_pos_x, ent_pos_y;
  logic [IdxW-1:0]                       live_off;
  logic                                  full, hazard_raw, hazard;
  logic                                  enq_fire, deq_fire, rt_fire;

  assign pending     = wr_ptr_q - rt_ptr_q;
  assign full        = (pending == PtrW'(QUEUE_DEPTH));
  assign hazard      = (CHECK_HAZARD != 0) && hazard_raw;
  assign enq_ready   = !reset && !full && !hazard;
  assign deq_valid   = (rd_ptr_q != wr_ptr_q);
  assign enq_fire    = enq_valid && enq_ready;
  assign deq_fire    = deq_valid && deq_ready;
  assign rt_fire     = retire_valid && (rt_ptr_q != rd_ptr_q);
  assign stall_count = stall_count_q;

  always_comb begin
    enq_lanes = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      enq_lanes[l].pos_x    = enq_pos_x[l*DIM_BITS +: DIM_BITS];
      enq_lanes[l].pos_y    = enq_pos_y[l*DIM_BITS +: DIM_BITS];
      enq_lanes[l].color    = enq_color[l*32 +: 32];
      enq_lanes[l].depth    = enq_depth[l*DEPTH_BITS +: DEPTH_BITS];
      enq_lanes[l].backface = enq_backface[l];
    end
  end

  // An entry is live when its offset from the oldest unretired slot is below the live count.
  always_comb begin
    live      = '0;
    live_off  = '0;
    ent_tmask = '0;
    ent_pos_x = '0;
    ent_pos_y = '0;
    for (int e = 0; e < QUEUE_DEPTH; e++) begin
      live_off = IdxW'(e) - rt_ptr_q[IdxW-1:0];
      live[e]  = ({1'b0, live_off} < pending);
      ent_tmask[e*NUM_LANES +: NUM_LANES] = tmask_q[e];
      for (int l = 0; l < NUM_LANES; l++) begin
        ent_pos_x[(e*NUM_LANES+l)*DIM_BITS +: DIM_BITS] = lane_q[e][l].pos_x;
        ent_pos_y[(e*NUM_LANES+l)*DIM_BITS +: DIM_BITS] = lane_q[e][l].pos_y;
      end
    end
  end

  rop_hazard_check #(
    .NUM_LANES   (NUM_LANES),
    .QUEUE_DEPTH (QUEUE_DEPTH),
    .DIM_BITS    (DIM_BITS)
  ) u_hazard (
    .live_i      (live),
    .ent_tmask_i (ent_tmask),
    .ent_pos_x_i (ent_pos_x),
    .ent_pos_y_i (ent_pos_y),
    .in_tmask_i  (enq_tmask),
    .in_pos_x_i  (enq_pos_x),
    .in_pos_y_i  (enq_pos_y),
    .hazard_o    (hazard_raw)
  );

  always_comb begin
    deq_tmask    = tmask_q[rd_ptr_q[IdxW-1:0]];
    deq_pos_x    = '0;
    deq_pos_y    = '0;
    deq_color    = '0;
    deq_depth    = '0;
    deq_backface = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      deq_pos_x[l*DIM_BITS +: DIM_BITS]     = lane_q[rd_ptr_q[IdxW-1:0]][l].pos_x;
      deq_pos_y[l*DIM_BITS +: DIM_BITS]     = lane_q[rd_ptr_q[IdxW-1:0]][l].pos_y;
      deq_color[l*32 +: 32]                 = lane_q[rd_ptr_q[IdxW-1:0]][l].color;
      deq_depth[l*DEPTH_BITS +: DEPTH_BITS] = lane_q[rd_ptr_q[IdxW-1:0]][l].depth;
      deq_backface[l]                       = lane_q[rd_ptr_q[IdxW-1:0]][l].backface;
    end
  end

  always_comb begin
    wr_ptr_d      = enq_fire ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d      = deq_fire ? rd_ptr_q + PtrOne : rd_ptr_q;
    rt_ptr_d      = rt_fire  ? rt_ptr_q + PtrOne : rt_ptr_q;
    // Stalls are counted only when space exists, so a full queue never inflates the count.
    stall_count_d = (enq_valid && !full && hazard) ? stall_count_q + 32'd1 : stall_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rt_ptr_q      <= '0;
      stall_count_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rt_ptr_q      <= rt_ptr_d;
      stall_count_q <= stall_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      tmask_q[wr_ptr_q[IdxW-1:0]] <= enq_tmask;
      lane_q[wr_ptr_q[IdxW-1:0]]  <= enq_lanes;
    end
  end

  retire_without_inflight_a : assert property (@(posedge clk) disable iff (reset)
      !(retire_valid && (rt_ptr_q == rd_ptr_q)))
    else $warning("rop_frag_queue: retire_valid with nothing in flight ignored");

endmodule

// File: tb/tb_rop_frag_queue.sv
// Bench for rop_frag_queue: request-level reference model plus a deq-side scoreboard monitor.
module tb_rop_frag_queue;

  localparam int L  = 4;
  localparam int D  = 8;
  localparam int DB = 16;
  localparam int ZB = 24;

  typedef struct packed {
    logic [L-1:0]      tmask;
    logic [L*DB-1:0]   x;
    logic [L*DB-1:0]   y;
    logic [L*32-1:0]   c;
    logic [L*ZB-1:0]   z;
    logic [L-1:0]      bf;
  } req_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enq_valid = 1'b0, deq_ready = 1'b0, retire_valid = 1'b0;
  logic enq_valid_nh = 1'b0, deq_ready_nh = 1'b0;
  req_t cur = '0;

  logic            enq_ready, deq_valid, enq_ready_nh, deq_valid_nh;
  logic [L-1:0]    deq_tmask, deq_bf, deq_tmask_nh, deq_bf_nh;
  logic [L*DB-1:0] deq_x, deq_y, deq_x_nh, deq_y_nh;
  logic [L*32-1:0] deq_c, deq_c_nh;
  logic [L*ZB-1:0] deq_z, deq_z_nh;
  logic [3:0]      pending, pending_nh;
  logic [31:0]     stall_count, stall_count_nh;

  int unsigned n_vec = 0, n_bad = 0;

  req_t        live_q[$];
  req_t        exp_q[$];
  int          n_buf = 0;
  int unsigned exp_stall = 0;

  always #5 clk = ~clk;

  rop_frag_queue #(.NUM_LANES(L), .QUEUE_DEPTH(D), .DIM_BITS(DB), .DEPTH_BITS(ZB),
                   .CHECK_HAZARD(1)) u_dut (
    .clk(clk), .reset(reset), .enq_valid(enq_valid), .enq_tmask(cur.tmask),
    .enq_pos_x(cur.x), .enq_pos_y(cur.y), .enq_color(cur.c), .enq_depth(cur.z),
    .enq_backface(cur.bf), .enq_ready(enq_ready), .deq_valid(deq_valid),
    .deq_tmask(deq_tmask), .deq_pos_x(deq_x), .deq_pos_y(deq_y), .deq_color(deq_c),
    .deq_depth(deq_z), .deq_backface(deq_bf), .deq_ready(deq_ready),
    .retire_valid(retire_valid), .pending(pending), .stall_count(stall_count)
  );

  rop_frag_queue #(.NUM_LANES(L), .QUEUE_DEPTH(D), .DIM_BITS(DB), .DEPTH_BITS(ZB),
                   .CHECK_HAZARD(0)) u_dut_nh (
    .clk(clk), .reset(reset), .enq_valid(enq_valid_nh), .enq_tmask(cur.tmask),
    .enq_pos_x(cur.x), .enq_pos_y(cur.y), .enq_color(cur.c), .enq_depth(cur.z),
    .enq_backface(cur.bf), .enq_ready(enq_ready_nh), .deq_valid(deq_valid_nh),
    .deq_tmask(deq_tmask_nh), .deq_pos_x(deq_x_nh), .deq_pos_y(deq_y_nh),
    .deq_color(deq_c_nh), .deq_depth(deq_z_nh), .deq_backface(deq_bf_nh),
    .deq_ready(deq_ready_nh), .retire_valid(1'b0), .pending(pending_nh),
    .stall_count(stall_count_nh)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Request-level overlap rule: any active lane pair at the same pixel.
  function automatic bit model_hazard(input req_t r);
    foreach (live_q[k])
      for (int j = 0; j < L; j++)
        for (int i = 0; i < L; i++)
          if (live_q[k].tmask[j] && r.tmask[i] &&
              live_q[k].x[j*DB +: DB] == r.x[i*DB +: DB] &&
              live_q[k].y[j*DB +: DB] == r.y[i*DB +: DB])
            return 1'b1;
    return 1'b0;
  endfunction

  function automatic req_t make_req(input logic [L-1:0] tm, input int lane, input int xv,
                                    input int yv);
    req_t r;
    r.tmask = tm;
    for (int l = 0; l < L; l++) begin
      r.x[l*DB +: DB] = (lane < 0 || l == lane) ? DB'(xv) : DB'(100 + l);
      r.y[l*DB +: DB] = (lane < 0 || l == lane) ? DB'(yv) : DB'(100 + l);
      r.c[l*32 +: 32] = $urandom;
      r.z[l*ZB +: ZB] = ZB'($urandom);
    end
    r.bf = L'($urandom);
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r = make_req(L'($urandom), -1, 0, 0);
    for (int l = 0; l < L; l++) begin
      r.x[l*DB +: DB] = DB'($urandom_range(7));
      r.y[l*DB +: DB] = DB'($urandom_range(3));
    end
    return r;
  endfunction

  // One clock: compare against the model at negedge, then advance the model.
  task automatic cycle();
    bit full, haz, rdy, ef, df, rf;
    @(negedge clk);
    full = (live_q.size() >= D);
    haz  = model_hazard(cur);
    rdy  = !full && !haz;
    check("enq_ready", 128'(enq_ready), 128'(rdy));
    check("deq_valid", 128'(deq_valid), 128'(n_buf > 0));
    check("pending", 128'(pending), 128'(live_q.size()));
    check("stall_count", 128'(stall_count), 128'(exp_stall));
    ef = enq_valid && rdy;
    df = deq_ready && (n_buf > 0);
    rf = retire_valid && ((live_q.size() - n_buf) > 0);
    if (enq_valid && !full && haz) exp_stall++;
    if (rf) void'(live_q.pop_front());
    if (df) n_buf--;
    if (ef) begin
      live_q.push_back(cur);
      exp_q.push_back(cur);
      n_buf++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    check("enq_ready_in_reset", 128'(enq_ready), 128'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    live_q.delete();
    exp_q.delete();
    n_buf = 0;
    exp_stall = 0;
  endtask

  task automatic drain();
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    for (int i = 0; i < 40 && live_q.size() > 0; i++) begin
      retire_valid = (live_q.size() - n_buf) > 0;
      cycle();
    end
    retire_valid = 1'b0;
    deq_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && deq_valid === 1'b1 && deq_ready) begin
      if (exp_q.size() == 0) begin
        check("deq_unexpected", 128'(1), 128'(0));
      end else begin
        req_t e;
        e = exp_q.pop_front();
        check("deq_tmask", 128'(deq_tmask), 128'(e.tmask));
        check("deq_pos_x", 128'(deq_x), 128'(e.x));
        check("deq_pos_y", 128'(deq_y), 128'(e.y));
        check("deq_color", 128'(deq_c), 128'(e.c));
        check("deq_depth", 128'(deq_z), 128'(e.z));
        check("deq_backface", 128'(deq_bf), 128'(e.bf));
      end
    end
  end

  initial begin
    req_t a;
    @(posedge clk);
    #1;
    do_reset();
    cycle();

    // Fill with distinct pixels; the 9th attempt must be refused.
    for (int k = 0; k < 9; k++) begin
      cur = make_req(4'hF, -1, k, 0);
      enq_valid = 1'b1;
      cycle();
    end
    // Full: enq+deq+retire together, enq refused then accepted (pending 8->7->8).
    cur = make_req(4'hF, -1, 50, 0);
    deq_ready = 1'b1;
    cycle();
    retire_valid = 1'b1;
    cycle();
    retire_valid = 1'b0;
    deq_ready = 1'b0;
    cycle();
    // Dequeue everything while still offering work: space only returns on retire.
    cur = make_req(4'hF, -1, 60, 0);
    deq_ready = 1'b1;
    repeat (10) cycle();
    retire_valid = 1'b1;
    cycle();
    retire_valid = 1'b0;
    cycle();
    drain();

    // Hazard stall: A lane0 (5,7) in flight blocks B lane2 (5,7) until A retires.
    cur = make_req(4'b0001, 0, 5, 7);
    enq_valid = 1'b1;
    cycle();
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    cycle();
    deq_ready = 1'b0;
    cur = make_req(4'b0100, 2, 5, 7);
    enq_valid = 1'b1;
    repeat (4) cycle();
    retire_valid = 1'b1;
    cycle();
    retire_valid = 1'b0;
    cycle();
    drain();

    // Masked lane: same pixel on an inactive lane does not stall.
    cur = make_req(4'b0001, 0, 5, 7);
    enq_valid = 1'b1;
    cycle();
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    cycle();
    deq_ready = 1'b0;
    cur = make_req(4'b1011, 2, 5, 7);
    enq_valid = 1'b1;
    cycle();
    cur = make_req(4'b0000, -1, 5, 7);
    cycle();
    drain();

    // Random traffic over a small pixel space so overlaps are common.
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(2) == 0) cur = rand_req();
      enq_valid    = ($urandom_range(3) != 0);
      deq_ready    = $urandom_range(1) == 1;
      retire_valid = ((live_q.size() - n_buf) > 0) && ($urandom_range(2) == 0);
      cycle();
    end
    drain();

    // Reset mid-stream with three live entries, then a stray retire.
    for (int k = 0; k < 3; k++) begin
      cur = make_req(4'hF, -1, 20 + k, 1);
      enq_valid = 1'b1;
      deq_ready = (k == 0);
      cycle();
    end
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    do_reset();
    retire_valid = 1'b1;
    cycle();
    retire_valid = 1'b0;
    cycle();

    // Hazard checking disabled: the overlapping request goes straight in.
    a = make_req(4'b0001, 0, 5, 7);
    cur = a;
    enq_valid_nh = 1'b1;
    @(negedge clk);
    check("nh_enq_ready_a", 128'(enq_ready_nh), 128'(1));
    @(posedge clk);
    #1;
    enq_valid_nh = 1'b0;
    deq_ready_nh = 1'b1;
    @(negedge clk);
    check("nh_deq_valid", 128'(deq_valid_nh), 128'(1));
    check("nh_deq_tmask", 128'(deq_tmask_nh), 128'(a.tmask));
    check("nh_deq_pos_x", 128'(deq_x_nh), 128'(a.x));
    check("nh_deq_pos_y", 128'(deq_y_nh), 128'(a.y));
    check("nh_deq_color", 128'(deq_c_nh), 128'(a.c));
    check("nh_deq_depth", 128'(deq_z_nh), 128'(a.z));
    check("nh_deq_backface", 128'(deq_bf_nh), 128'(a.bf));
    @(posedge clk);
    #1;
    deq_ready_nh = 1'b0;
    cur = make_req(4'b0100, 2, 5, 7);
    enq_valid_nh = 1'b1;
    @(negedge clk);
    check("nh_enq_ready_b", 128'(enq_ready_nh), 128'(1));
    check("nh_pending_b", 128'(pending_nh), 128'(1));
    @(posedge clk);
    #1;
    enq_valid_nh = 1'b0;
    @(negedge clk);
    check("nh_pending_after", 128'(pending_nh), 128'(2));
    check("nh_stall_count", 128'(stall_count_nh), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
